rgb_response_router: RTL and testbench

//  Downstream consumer of the RGB FIFO filled by the read master. Each read master response is a two-word pair:
//  a data word (texel / z-buffer value), then a core-ID word. This block pops each pair in order and

---
 rtl/rgb_response_router_pkg.sv | 18 +
 rtl/rgb_response_router_sat_counter.sv | 20 ++
 rtl/rgb_response_router.sv | 112 +++++++++++
 tb/tb_rgb_response_router.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_response_router_pkg.sv
// Shared types and default sizing for the RGB response router.
package rgb_route_pkg;

    localparam int unsigned RGB_NUM_CORES = 8;
    localparam int unsigned RGB_CORE_ID_W = 8;
    localparam int unsigned RGB_DATA_W    = 32;
    localparam int unsigned RGB_CNT_W     = 16;

    // Each response is a data word followed by a core-ID word.
    typedef enum logic [2:0] {
        S_POP_DATA = 3'd0,
        S_CAP_DATA = 3'd1,
        S_POP_ID   = 3'd2,
        S_CAP_ID   = 3'd3,
        S_DELIVER  = 3'd4
    } router_state_t;

endpackage

// File: rtl/rgb_response_router_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             iClk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count events, never wrapping past the maximum value.
    always_ff @(posedge iClk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rgb_response_router.sv
// RGB response router: pops data/core-ID pairs from the RGB FIFO and hands
// each data word to the addressed core over a valid/ready handshake.
// Optional statistics counters are enabled with macro RGB_ROUTER_STATS_EN.
module rgb_response_router
    import rgb_route_pkg::*;
#(
    parameter int unsigned NUM_CORES = RGB_NUM_CORES,
    parameter int unsigned CORE_ID_W = RGB_CORE_ID_W,
    parameter int unsigned DATA_W    = RGB_DATA_W,
    parameter int unsigned CNT_W     = RGB_CNT_W
) (
    input  logic                 iClk,
    input  logic                 iRstn,
    input  logic                 FF_rgb_empty,
    output logic                 FF_rgb_readrequest,
    input  logic [DATA_W-1:0]    FF_rgb_q,
    output logic [NUM_CORES-1:0] oResp_valid,
    input  logic [NUM_CORES-1:0] iResp_ready,
    output logic [DATA_W-1:0]    oResp_data,
    output logic                 oBusy,
    output logic [CNT_W-1:0]     oDeliver_count,
    output logic [CNT_W-1:0]     oDrop_count
);

    router_state_t        state;
    router_state_t        state_nxt;
    logic [DATA_W-1:0]    data_reg;
    logic [CORE_ID_W-1:0] id_reg;
    logic                 id_ok;
    logic                 deliver_hs;
    logic [NUM_CORES-1:0] dest_onehot;

    // An ID word is usable only if its upper field is clear and it names an existing core.
    assign id_ok = (FF_rgb_q[DATA_W-1:CORE_ID_W] == '0) &&
                   (32'(FF_rgb_q[CORE_ID_W-1:0]) < NUM_CORES);

    assign dest_onehot = NUM_CORES'(1) << id_reg;
    assign oBusy       = (state != S_POP_DATA);

    // Next-state and output decode; nothing is driven while reset is asserted.
    always_comb begin
        state_nxt          = state;
        FF_rgb_readrequest = 1'b0;
        oResp_valid        = '0;
        oResp_data         = '0;
        deliver_hs         = 1'b0;
        if (iRstn) begin
            unique case (state)
                S_POP_DATA: begin
                    FF_rgb_readrequest = !FF_rgb_empty;
                    if (!FF_rgb_empty) state_nxt = S_CAP_DATA;
                end
                S_CAP_DATA: begin
                    state_nxt = S_POP_ID;
                end
                S_POP_ID: begin
                    FF_rgb_readrequest = !FF_rgb_empty;
                    if (!FF_rgb_empty) state_nxt = S_CAP_ID;
                end
                S_CAP_ID: begin
                    state_nxt = id_ok ? S_DELIVER : S_POP_DATA;
                end
                S_DELIVER: begin
                    oResp_valid = dest_onehot;
                    oResp_data  = data_reg;
                    deliver_hs  = |(iResp_ready & dest_onehot);
                    if (deliver_hs) state_nxt = S_POP_DATA;
                end
                default: begin
                    state_nxt = S_POP_DATA;
                end
            endcase
        end
    end

    // State register plus capture of the data and ID words one cycle after each pop.
    always_ff @(posedge iClk) begin
        if (!iRstn) begin
            state    <= S_POP_DATA;
            data_reg <= '0;
            id_reg   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CAP_DATA) data_reg <= FF_rgb_q;
            if (state == S_CAP_ID)   id_reg   <= FF_rgb_q[CORE_ID_W-1:0];
        end
    end

`ifdef RGB_ROUTER_STATS_EN
    logic drop_evt;

    assign drop_evt = (state == S_CAP_ID) && !id_ok && iRstn;

    sat_counter #(.CNT_W(CNT_W)) u_deliver_cnt (
        .iClk  (iClk),
        .clear (!iRstn),
        .inc   (deliver_hs),
        .count (oDeliver_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .iClk  (iClk),
        .clear (!iRstn),
        .inc   (drop_evt),
        .count (oDrop_count)
    );
`else
    assign oDeliver_count = '0;
    assign oDrop_count    = '0;
`endif

endmodule

// File: tb/tb_rgb_response_router.sv
// Scoreboard bench for rgb_response_router with a queue-based FIFO model and
// a reference model that classifies each pair from its ID word value.
module tb_rgb_response_router;

    localparam int NC = 8;
    localparam int DW = 32;
    localparam int CW = 4;

    typedef struct {
        int          core;
        logic [31:0] data;
    } exp_t;

    logic          iClk = 1'b0;
    logic          iRstn = 1'b0;
    logic          FF_rgb_empty;
    logic          FF_rgb_readrequest;
    logic [DW-1:0] FF_rgb_q = '0;
    logic [NC-1:0] oResp_valid;
    logic [NC-1:0] iResp_ready = '0;
    logic [DW-1:0] oResp_data;
    logic          oBusy;
    logic [CW-1:0] oDeliver_count;
    logic [CW-1:0] oDrop_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:1023];
    int pushes = 0;
    int pops   = 0;

    exp_t exp_q[$];
    int   hs_times[$];
    int   exp_deliv = 0;
    int   exp_drops = 0;

    rgb_response_router #(
        .NUM_CORES (NC),
        .CORE_ID_W (8),
        .DATA_W    (DW),
        .CNT_W     (CW)
    ) dut (
        .iClk               (iClk),
        .iRstn              (iRstn),
        .FF_rgb_empty       (FF_rgb_empty),
        .FF_rgb_readrequest (FF_rgb_readrequest),
        .FF_rgb_q           (FF_rgb_q),
        .oResp_valid        (oResp_valid),
        .iResp_ready        (iResp_ready),
        .oResp_data         (oResp_data),
        .oBusy              (oBusy),
        .oDeliver_count     (oDeliver_count),
        .oDrop_count        (oDrop_count)
    );

    always #5 iClk = ~iClk;

    // Normal-mode FIFO: q shows the popped word on the cycle after readrequest.
    assign FF_rgb_empty = (pushes == pops);
    always @(posedge iClk) begin
        if (FF_rgb_readrequest) begin
            FF_rgb_q <= mem[pops % 1024];
            pops     <= pops + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected statistics value; zero when the counters are not built.
    function automatic logic [CW-1:0] exp_cnt(input int n);
        int lim = 0;
`ifdef RGB_ROUTER_STATS_EN
        lim = (1 << CW) - 1;
`endif
        return (n >= lim) ? CW'(lim) : CW'(n);
    endfunction

    task automatic push_word(input logic [31:0] w);
        mem[pushes % 1024] = w;
        pushes++;
    endtask

    // Reference model: an ID word addresses a core only if its whole value is below NC.
    task automatic expect_pair(input logic [31:0] d, input logic [31:0] idw, input bit record);
        exp_t e;
        if (record) begin
            if (idw < 32'(NC)) begin
                e.core = int'(idw);
                e.data = d;
                exp_q.push_back(e);
                exp_deliv++;
            end else begin
                exp_drops++;
            end
        end
    endtask

    task automatic push_pair(input logic [31:0] d, input logic [31:0] idw, input bit record);
        push_word(d);
        push_word(idw);
        expect_pair(d, idw, record);
    endtask

    task automatic wait_idle(input bit rnd);
        int n = 0;
        while (!(exp_q.size() == 0 && pushes == pops && !oBusy && iRstn)) begin
            @(negedge iClk);
            if (rnd) iResp_ready = NC'($urandom);
            n++;
            if (n > 3000) begin
                check("idle_timeout", 64'(n), 64'd0);
                break;
            end
        end
        repeat (2) @(negedge iClk);
    endtask

    // Monitor: compares every presented response against the scoreboard head.
    logic [NC-1:0] prev_valid = '0;
    logic [DW-1:0] prev_data = '0;
    bit            prev_pending = 1'b0;
    int            cyc = 0;
    int            mon_idx;
    always begin
        @(negedge iClk);
        #1;
        cyc++;
        check("rr_while_empty", 64'(FF_rgb_readrequest & FF_rgb_empty), 64'd0);
        if (!iRstn) begin
            prev_pending = 1'b0;
        end else if (oResp_valid != '0) begin
            if (prev_pending) begin
                check("valid_stable", 64'(oResp_valid), 64'(prev_valid));
                check("data_stable", 64'(oResp_data), 64'(prev_data));
            end
            if ($countones(oResp_valid) != 1) begin
                check("valid_onehot", 64'($countones(oResp_valid)), 64'd1);
                prev_pending = 1'b0;
            end else if (exp_q.size() == 0) begin
                check("unexpected_resp", 64'(oResp_valid), 64'd0);
                prev_pending = 1'b0;
            end else begin
                mon_idx = 0;
                for (int i = 0; i < NC; i++) if (oResp_valid[i]) mon_idx = i;
                check("resp_core", 64'(mon_idx), 64'(exp_q[0].core));
                check("resp_data", 64'(oResp_data), 64'(exp_q[0].data));
                if (|(iResp_ready & oResp_valid)) begin
                    void'(exp_q.pop_front());
                    hs_times.push_back(cyc);
                    prev_pending = 1'b0;
                end else begin
                    prev_pending = 1'b1;
                    prev_valid   = oResp_valid;
                    prev_data    = oResp_data;
                end
            end
        end else begin
            if (prev_pending) check("valid_withdrawn", 64'd0, 64'd1);
            prev_pending = 1'b0;
        end
    end

    initial begin
        logic [31:0] d;
        logic [31:0] idw;
        int          r;
        int          p0;
        int          hs0;

        // Reset state
        repeat (3) @(negedge iClk);
        #1;
        check("rst_valid", 64'(oResp_valid), 64'd0);
        check("rst_data", 64'(oResp_data), 64'd0);
        check("rst_rr", 64'(FF_rgb_readrequest), 64'd0);
        check("rst_busy", 64'(oBusy), 64'd0);
        check("rst_deliver_cnt", 64'(oDeliver_count), 64'(exp_cnt(0)));
        check("rst_drop_cnt", 64'(oDrop_count), 64'(exp_cnt(0)));
        @(negedge iClk);
        iRstn = 1'b1;
        @(negedge iClk);

        // 1: single pair, ready high, valid exactly in cycle 4 for one cycle
        iResp_ready = '1;
        push_pair(32'h00AABBCC, 32'h3, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge iClk);
            #1;
            check("t1_valid_latency", 64'(oResp_valid), (k == 4) ? 64'h08 : 64'h00);
            if (k == 4) check("t1_data", 64'(oResp_data), 64'h00AABBCC);
        end
        wait_idle(1'b0);

        // 2: addressed core not ready for 10 cycles; other ready bits ignored
        iResp_ready = 8'b0000_0100;
        push_pair(32'h1234, 32'h5, 1'b1);
        repeat (4) @(negedge iClk);
        #1;
        p0 = pops;
        for (int k = 0; k < 10; k++) begin
            check("t2_valid_held", 64'(oResp_valid), 64'h20);
            check("t2_no_pops", 64'(pops), 64'(p0));
            @(negedge iClk);
            #1;
        end
        @(negedge iClk);
        iResp_ready = 8'b0010_0100;
        @(negedge iClk);
        #1;
        check("t2_valid_cleared", 64'(oResp_valid), 64'd0);
        check("t2_idle", 64'(oBusy), 64'd0);
        repeat (3) @(negedge iClk);
        #1;
        check("t2_no_extra_pops", 64'(pops), 64'(p0));
        wait_idle(1'b0);

        // 3: ID word arrives 6 cycles after the data word
        iResp_ready = '1;
        push_word(32'hCAFE0003);
        repeat (6) begin
            @(negedge iClk);
            #1;
        end
        check("t3_busy_waiting", 64'(oBusy), 64'd1);
        check("t3_rr_low_empty", 64'(FF_rgb_readrequest), 64'd0);
        check("t3_no_valid", 64'(oResp_valid), 64'd0);
        @(negedge iClk);
        push_word(32'h6);
        expect_pair(32'hCAFE0003, 32'h6, 1'b1);
        repeat (2) @(negedge iClk);
        #1;
        check("t3_valid_after_id", 64'(oResp_valid), 64'h40);
        wait_idle(1'b0);

        // 4: out-of-range ID and non-zero upper field are both dropped
        push_pair(32'hDEAD0001, 32'h8, 1'b1);
        push_pair(32'hDEAD0002, 32'h01000002, 1'b1);
        wait_idle(1'b0);
        check("t4_drop_cnt", 64'(oDrop_count), 64'(exp_cnt(exp_drops)));
        check("t4_deliver_cnt", 64'(oDeliver_count), 64'(exp_cnt(exp_deliv)));

        // 5: four back-to-back pairs, one delivery every 5 cycles
        hs0 = hs_times.size();
        push_pair(32'h50000000, 32'h0, 1'b1);
        push_pair(32'h50000001, 32'h1, 1'b1);
        push_pair(32'h50000002, 32'h2, 1'b1);
        push_pair(32'h50000003, 32'h0, 1'b1);
        wait_idle(1'b0);
        check("t5_deliveries", 64'(hs_times.size() - hs0), 64'd4);
        for (int i = 1; i < 4; i++) begin
            if (hs0 + i < hs_times.size())
                check("t5_interval", 64'(hs_times[hs0 + i] - hs_times[hs0 + i - 1]), 64'd5);
        end
        check("t5_deliver_cnt", 64'(oDeliver_count), 64'(exp_cnt(exp_deliv)));

        // 6: reset while in S_CAP_ID loses the pair; a later pair is delivered
        push_pair(32'h5555AAAA, 32'h6, 1'b0);
        repeat (3) @(negedge iClk);
        iRstn = 1'b0;
        exp_deliv = 0;
        exp_drops = 0;
        @(negedge iClk);
        #1;
        check("t6_valid", 64'(oResp_valid), 64'd0);
        check("t6_data", 64'(oResp_data), 64'd0);
        check("t6_busy", 64'(oBusy), 64'd0);
        check("t6_deliver_cnt", 64'(oDeliver_count), 64'd0);
        check("t6_drop_cnt", 64'(oDrop_count), 64'd0);
        push_pair(32'h0BADF00D, 32'h2, 1'b1);
        #1;
        check("t6_rr_in_reset", 64'(FF_rgb_readrequest), 64'd0);
        @(negedge iClk);
        iRstn = 1'b1;
        wait_idle(1'b0);
        check("t6_deliver_after", 64'(oDeliver_count), 64'(exp_cnt(exp_deliv)));

        // Random pairs with random gaps and random ready; counters saturate
        for (int p = 0; p < 40; p++) begin
            d = $urandom;
            r = $urandom_range(0, 9);
            if (r < 8)       idw = 32'(r);
            else if (r == 8) idw = 32'(8 + $urandom_range(0, 247));
            else             idw = $urandom | 32'h100;
            push_word(d);
            repeat ($urandom_range(0, 2)) begin
                @(negedge iClk);
                iResp_ready = NC'($urandom);
            end
            push_word(idw);
            expect_pair(d, idw, 1'b1);
            repeat ($urandom_range(1, 4)) begin
                @(negedge iClk);
                iResp_ready = NC'($urandom);
            end
        end
        wait_idle(1'b1);
        check("rand_deliver_cnt", 64'(oDeliver_count), 64'(exp_cnt(exp_deliv)));
        check("rand_drop_cnt", 64'(oDrop_count), 64'(exp_cnt(exp_drops)));
        check("sb_leftover", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
